// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit timing,
// used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 32;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a host-side producer and the UART transmitter.
interface uart_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle
// of each bit with tick. Held at zero while clear is high.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1/8N2 LSB first with a fixed bit period.
// Define UART_TX_PARITY_EN to append an even-parity bit (8E1/8E2).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_tx_if.slave  bus,
  output logic      tx,
  output logic      tx_busy,
  output logic      tx_done
);

  logic [2:0] state;
  logic [2:0] state_next;
  logic [7:0] shift_reg;
  logic [2:0] bit_idx;
  logic       stop_idx;
  logic       stop_last;
  logic       tick;
  logic       accept;
  logic       line_next;
`ifdef UART_TX_PARITY_EN
  logic       parity_bit;
`endif

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == ST_IDLE),
    .tick  (tick)
  );

  assign accept    = bus.tx_valid && bus.tx_ready;
  assign stop_last = (STOP_BITS == 1) || stop_idx;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = ST_START;
      ST_START: if (tick) state_next = ST_DATA;
      ST_DATA: begin
        if (tick && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_next = ST_PARITY;
`else
          state_next = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (tick) state_next = ST_STOP;
`endif
      ST_STOP:  if (tick && stop_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    line_next = 1'b1;
    case (state)
      ST_START:  line_next = 1'b0;
      ST_DATA:   line_next = shift_reg[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: line_next = parity_bit;
`endif
      default:   line_next = 1'b1;
    endcase
  end

  // Line outputs trail the FSM by one cycle, so the idle/ready state of
  // the FSM overlaps the last frame cycle and back-to-back frames leave
  // exactly one idle-high cycle between them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      shift_reg    <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      bus.tx_ready <= 1'b0;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit   <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      bus.tx_ready <= (state_next == ST_IDLE);
      tx           <= line_next;
      tx_busy      <= (state != ST_IDLE);
      tx_done      <= (state == ST_STOP) && tick && stop_last;
      if (accept) begin
        shift_reg  <= bus.tx_data;
        bit_idx    <= '0;
        stop_idx   <= 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_bit <= ^bus.tx_data;
`endif
      end else if (state == ST_DATA && tick) begin
        shift_reg <= shift_reg >> 1;
        bit_idx   <= bit_idx + 3'd1;
      end else if (state == ST_STOP && tick) begin
        stop_idx  <= ~stop_idx;
      end
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter serialising 8-bit bytes onto a single `tx` line: 8N1 by default, LSB first, with a fixed clock-cycle bit period. It is the counterpart of the team's UART receiver and uses the same bit timing (32 clocks per bit at 781250 baud). It accepts bytes through a valid/ready handshake from a host-side producer, such as a response or echo path, and drives the board TX pin.

## Interface
- `CLKS_PER_BIT`, 32: clock cycles per serial bit; legal range 2..65535.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `tx_data` input 8: byte to send; sampled only on acceptance.
- `tx_valid` input 1: producer has a byte.
- `tx_ready` output 1: transmitter can accept; reset value 0.
- `tx` output 1: serial line, idle high; reset value 1.
- `tx_busy` output 1: frame in progress; reset value 0.
- `tx_done` output 1: one-cycle pulse at the end of a frame; reset value 0.

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - `tx`=1, `tx_ready`=1, `tx_busy`=0.
  - Acceptance happens when `tx_valid && tx_ready` on a rising edge. On acceptance, latch `tx_data` into the shift register, clear the bit counter and the bit index, and go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - `tx` = shift_reg[0] for CLKS_PER_BIT cycles, then shift right and increment the bit index.
  - After index 7 completes, go to PARITY if the macro is defined, otherwise STOP.
- PARITY: `tx` = parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - `tx_done`=1 in the final cycle of the stop period; the next state is IDLE.
- `tx_busy`=1 in every state except IDLE. `tx_ready`=0 in every state except IDLE.
- `tx` is driven from a register, so it never glitches.
- Bit counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. Width is $clog2(CLKS_PER_BIT).
- Stop counter: for STOP_BITS=2 the counter spans two bit periods, tracked by a stop-bit index.
- Changes to `tx_data` while not in IDLE are ignored. `tx_valid` held high while busy has no effect.
- Reset asserted mid-frame: immediately (asynchronously) `tx`=1, `tx_ready`=0, `tx_busy`=0, `tx_done`=0, state IDLE. No partial frame resumes.
- First cycle after reset release: `tx_ready` rises at the first clock edge, and acceptance is possible from the second edge onward.

## Timing
- Acceptance at edge N: `tx` falls after edge N+1 and the start bit occupies cycles N+1..N+CLKS_PER_BIT.
- Frame length: (1 + 8 + P + STOP_BITS)×CLKS_PER_BIT cycles, where P=1 with the parity macro and 0 without. With defaults this is 320 cycles.
- `tx_done` is high during the last frame cycle. The following cycle is IDLE with `tx_ready`=1.
- Back-to-back frames: if `tx_valid` is held, the next start bit begins two cycles after `tx_done`, giving exactly one extra idle-high cycle between frames.
- No combinational path from inputs to outputs.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: an even-parity bit (XOR of the 8 data bits) is sent after bit 7 and the frame is 8E1/8E2.
  - Undefined: the PARITY state and its logic are absent and the frame is 8N1/8N2.

## Structure
- The shared package `uart_pkg` holds:
  - the state encoding constants (IDLE, START, DATA, PARITY, STOP);
  - the default `CLKS_PER_BIT` = 32, which the receiver uses as well.
- One sub-module, `uart_baud_cnt`, is natural. It is a bit-period counter with a clear input and a `tick` output asserted on the last cycle of each bit. It is reusable by the receiver.

## Test plan
- Reset: hold `rst_n`=0 with `tx_valid`=1 → `tx`=1, `tx_ready`=0, `tx_busy`=0. After release, `tx_ready`=1 within 1 cycle.
- Single byte 0x55, defaults, no macro:
  - `tx` is low for 32 cycles, then data bits 1,0,1,0,1,0,1,0 with 32 cycles each, then high.
  - `tx_done` pulses at frame cycle 320.
  - `tx_ready` is 0 throughout the frame.
- Back-to-back: `tx_valid` held with 0xA5 then 0x3C → two frames of 320 cycles separated by exactly 1 idle-high cycle. The bench decodes 0xA5, 0x3C.
- Mid-frame reset: assert `rst_n`=0 during DATA bit 3 of 0xF0 → `tx`=1 the same cycle. After release, sending 0x81 produces a clean, complete frame.
- `UART_TX_PARITY_EN` defined, byte 0x07 → parity bit 1 and frame of 352 cycles. Byte 0x03 → parity bit 0.
- `CLKS_PER_BIT`=2, `STOP_BITS`=2, byte 0xFF → frame of 22 cycles. The stop level holds for 4 cycles before `tx_done`.
